// File: rtl/field_lock.sv
// field_lock: piece-lock and line-clear engine that owns the 20x20 playfield.
//
// A start request merges the latched 4x4 piece into the field in a single
// WRITE cycle. SCAN then walks the rows from 19 up to 0, one row per cycle.
// Each full row is removed by shifting every row above it down by one.
// o_field is driven straight from the field register, so it never has a
// combinational path from any input.
//
// Request handshake: i_start or i_clear is taken only on an edge where
// o_busy is low, and i_clear has priority over i_start. While o_busy is
// high, both requests are dropped rather than queued. o_done pulses for
// exactly one cycle when a lock completes, and o_busy falls on the next edge.
//
// Ports:
//   i_clk            system clock; all state changes on the rising edge
//   i_rst            synchronous active-high reset (zeroes the field as well)
//   i_start          lock request
//   i_clear          zero the field
//   i_block          4x4 piece bitmap, bit by*4+bx
//   i_block_pos_x    piece column origin
//   i_block_pos_y    piece row origin, row 0 at the top
//   i_rotate         rotation, only [1:0] is used
//   o_field          playfield, bit y*20+x set = occupied
//   o_busy           high whenever the engine is not idle
//   o_done           one-cycle pulse at the end of a lock
//   o_lines_cleared  rows removed by the last lock (saturates at 7)
//   o_oob            last lock dropped a set cell outside the field
//   o_overlap        last lock wrote a cell that was already occupied
//   o_state          current FSM state (0 IDLE, 1 WRITE, 2 SCAN, 3 DONE)
module field_lock (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic         i_clear,
  input  logic [15:0]  i_block,
  input  logic [4:0]   i_block_pos_x,
  input  logic [4:0]   i_block_pos_y,
  input  logic [2:0]   i_rotate,
  output logic [399:0] o_field,
  output logic         o_busy,
  output logic         o_done,
  output logic [2:0]   o_lines_cleared,
  output logic         o_oob,
  output logic         o_overlap,
  output logic [1:0]   o_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_SCAN  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [399:0] r_field;
  logic [15:0]  r_blk;
  logic [4:0]   r_px;
  logic [4:0]   r_py;
  logic [1:0]   r_rot;
  logic [4:0]   r_row;
  logic [2:0]   r_lines;
  logic         r_oob;
  logic         r_ovl;

  logic [399:0] w_wr_field;
  logic         w_wr_oob;
  logic         w_wr_ovl;
  logic [399:0] w_shift_field;
  logic         w_row_full;
  logic [3:0]   w_src;
  logic [5:0]   w_cx;
  logic [5:0]   w_cy;
  logic [8:0]   w_idx;
  logic         w_unused_rot;

  assign w_unused_rot = i_rotate[2];

  // Merge the latched piece into the current field.
  // Target coordinates are 6 bits wide, so pos + offset cannot wrap back
  // into the field.
  always_comb begin
    w_wr_field = r_field;
    w_wr_oob   = 1'b0;
    w_wr_ovl   = 1'b0;
    w_src      = 4'd0;
    w_cx       = 6'd0;
    w_cy       = 6'd0;
    w_idx      = 9'd0;
    for (int by = 0; by < 4; by++) begin
      for (int bx = 0; bx < 4; bx++) begin
        case (r_rot)
          2'd0:    w_src = 4'(by * 4 + bx);
          2'd1:    w_src = 4'(12 + by - 4 * bx);
          2'd2:    w_src = 4'(15 - 4 * by - bx);
          default: w_src = 4'(3 - by + 4 * bx);
        endcase
        w_cx  = {1'b0, r_px} + 6'(bx);
        w_cy  = {1'b0, r_py} + 6'(by);
        w_idx = 9'(w_cy) * 9'd20 + 9'(w_cx);
        if (r_blk[w_src]) begin
          if (w_cx < 6'd20 && w_cy < 6'd20) begin
            if (r_field[w_idx]) w_wr_ovl = 1'b1;
            w_wr_field[w_idx] = 1'b1;
          end else begin
            w_wr_oob = 1'b1;
          end
        end
      end
    end
  end

  // Row collapse for the row under the pointer.
  // Rows 1..r_row take the row above them, row 0 becomes empty, and rows
  // below the pointer are untouched.
  always_comb begin
    w_row_full    = &r_field[9'(r_row) * 9'd20 +: 20];
    w_shift_field = r_field;
    for (int k = 1; k < 20; k++) begin
      if (5'(k) <= r_row) w_shift_field[k*20 +: 20] = r_field[(k-1)*20 +: 20];
    end
    w_shift_field[19:0] = 20'd0;
  end

  // FSM next state and state-derived outputs
  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (!i_clear && i_start) w_state_nxt = S_WRITE;
      end
      S_WRITE: w_state_nxt = S_SCAN;
      S_SCAN: begin
        // A cleared row keeps the pointer in place so the row that dropped
        // into it is checked on the next cycle.
        if (!w_row_full && r_row == 5'd0) w_state_nxt = S_DONE;
      end
      default: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_field <= '0;
      r_blk   <= '0;
      r_px    <= '0;
      r_py    <= '0;
      r_rot   <= '0;
      r_row   <= '0;
      r_lines <= '0;
      r_oob   <= 1'b0;
      r_ovl   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_clear) begin
            r_field <= '0;
          end else if (i_start) begin
            r_blk   <= i_block;
            r_px    <= i_block_pos_x;
            r_py    <= i_block_pos_y;
            r_rot   <= i_rotate[1:0];
            r_lines <= '0;
            r_oob   <= 1'b0;
            r_ovl   <= 1'b0;
          end
        end
        S_WRITE: begin
          r_field <= w_wr_field;
          r_oob   <= w_wr_oob;
          r_ovl   <= w_wr_ovl;
          r_row   <= 5'd19;
        end
        S_SCAN: begin
          if (w_row_full) begin
            r_field <= w_shift_field;
            if (r_lines != 3'd7) r_lines <= r_lines + 3'd1;
          end else if (r_row != 5'd0) begin
            r_row <= r_row - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_field         = r_field;
  assign o_lines_cleared = r_lines;
  assign o_oob           = r_oob;
  assign o_overlap       = r_ovl;
  assign o_state         = r_state;

endmodule

// File: tb/tb_field_lock.sv
// tb_field_lock: directed bench for field_lock.
// The playfield model is a 20x20 grid. A lock drops the rotated piece onto
// the grid, then compacts it by dropping every full row. The model also
// predicts busy/done timing from how many rows the lock clears.
module tb_field_lock;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         clear = 1'b0;
  logic [15:0]  block = '0;
  logic [4:0]   pos_x = '0;
  logic [4:0]   pos_y = '0;
  logic [2:0]   rot = '0;
  logic [399:0] o_field;
  logic         o_busy;
  logic         o_done;
  logic [2:0]   o_lines;
  logic         o_oob;
  logic         o_ovl;
  logic [1:0]   o_state;

  always #5 clk = ~clk;

  field_lock dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_clear(clear),
    .i_block(block), .i_block_pos_x(pos_x), .i_block_pos_y(pos_y),
    .i_rotate(rot), .o_field(o_field), .o_busy(o_busy), .o_done(o_done),
    .o_lines_cleared(o_lines), .o_oob(o_oob), .o_overlap(o_ovl),
    .o_state(o_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_f(input string name, input logic [399:0] act, input logic [399:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_cells[20][20];
  bit         m_valid = 0;
  bit         m_active = 0;
  int         m_k = 0;
  int         m_len = 0;
  logic [2:0] m_lines = '0;
  bit         m_oob = 0;
  bit         m_ovl = 0;

  function automatic logic [399:0] m_pack();
    logic [399:0] v;
    v = '0;
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 20; x++)
        v[y*20+x] = m_cells[y][x];
    return v;
  endfunction

  task automatic m_zero();
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 20; x++)
        m_cells[y][x] = 0;
  endtask

  // Drop the rotated piece, then keep only the non-full rows, stacked
  // from the bottom up.
  task automatic m_lock(input logic [15:0] b, input int px, input int py, input int r);
    bit grid[20][20];
    int sx, sy, x, y, dst, n;
    bit full;
    m_oob = 0;
    m_ovl = 0;
    for (int by = 0; by < 4; by++) begin
      for (int bx = 0; bx < 4; bx++) begin
        case (r)
          0:       begin sx = bx;     sy = by;     end
          1:       begin sx = by;     sy = 3 - bx; end
          2:       begin sx = 3 - bx; sy = 3 - by; end
          default: begin sx = 3 - by; sy = bx;     end
        endcase
        if (b[sy*4+sx]) begin
          x = px + bx;
          y = py + by;
          if (x < 20 && y < 20) begin
            if (m_cells[y][x]) m_ovl = 1;
            m_cells[y][x] = 1;
          end else begin
            m_oob = 1;
          end
        end
      end
    end
    for (int yy = 0; yy < 20; yy++)
      for (int xx = 0; xx < 20; xx++)
        grid[yy][xx] = 0;
    dst = 19;
    n = 0;
    for (int yy = 19; yy >= 0; yy--) begin
      full = 1;
      for (int xx = 0; xx < 20; xx++) if (!m_cells[yy][xx]) full = 0;
      if (full) n++;
      else begin
        for (int xx = 0; xx < 20; xx++) grid[dst][xx] = m_cells[yy][xx];
        dst--;
      end
    end
    m_cells = grid;
    m_lines = 3'((n > 7) ? 7 : n);
    m_len   = 22 + n;
  endtask

  // Compare process: runs every cycle on the falling edge. Inputs are
  // driven just after the rising edge, so they are stable here for the
  // upcoming edge.
  always @(negedge clk) begin
    if (o_done === 1'b1) done_cnt++;
    if (m_valid) begin
      if (m_active) begin
        m_k++;
        if (m_k > m_len) m_active = 0;
      end
      chk("busy", 32'(o_busy), 32'(m_active));
      chk("done", 32'(o_done), 32'(m_active && m_k == m_len));
      if (!m_active || m_k == m_len) begin
        chk_f("field", o_field, m_pack());
        chk("lines", 32'(o_lines), 32'(m_lines));
        chk("oob", 32'(o_oob), 32'(m_oob));
        chk("overlap", 32'(o_ovl), 32'(m_ovl));
      end
    end
    if (rst) begin
      m_zero();
      m_active = 0;
      m_lines  = '0;
      m_oob    = 0;
      m_ovl    = 0;
      m_valid  = 1;
    end else if (m_valid && !m_active) begin
      if (clear) m_zero();
      else if (start) begin
        m_lock(block, int'(pos_x), int'(pos_y), int'(rot[1:0]));
        m_active = 1;
        m_k = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  // Issue one lock and return the cycle on which done was seen, counted
  // from the accepting edge. A nonzero pulse_at re-pulses start in that
  // cycle while the lock is still busy.
  task automatic do_lock(input logic [15:0] b, input logic [4:0] x, input logic [4:0] y,
                         input logic [2:0] r, input int pulse_at, output int lat);
    block = b; pos_x = x; pos_y = y; rot = r;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 60; i++) begin
      start = (i == pulse_at);
      @(negedge clk);
      if (o_done === 1'b1) begin
        lat = i;
        break;
      end
      tick();
    end
    start = 1'b0;
    if (lat < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: no done within 60 cycles");
    end else begin
      tick();
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [399:0] e;
    int lat;

    // Reset held for two cycles
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_f("rst_field", o_field, '0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_lines", 32'(o_lines), 0);

    // Simple lock: 2x2 square at (5,18)
    do_lock(16'h0033, 5'd5, 5'd18, 3'd0, 0, lat);
    e = '0; e[365] = 1'b1; e[366] = 1'b1; e[385] = 1'b1; e[386] = 1'b1;
    chk_f("simple_field", o_field, e);
    chk("simple_lat", 32'(lat), 22);
    chk("simple_lines", 32'(o_lines), 0);
    chk("simple_oob", 32'(o_oob), 0);

    // Rotation: horizontal I piece turned once becomes column 3
    do_clear();
    do_lock(16'h000F, 5'd0, 5'd0, 3'd1, 0, lat);
    e = '0; e[3] = 1'b1; e[23] = 1'b1; e[43] = 1'b1; e[63] = 1'b1;
    chk_f("rot1_field", o_field, e);
    do_clear();
    do_lock(16'h000F, 5'd0, 5'd0, 3'd5, 0, lat);
    chk_f("rot5_field", o_field, e);
    do_clear();
    do_lock(16'h0072, 5'd7, 5'd3, 3'd2, 0, lat);
    do_clear();
    do_lock(16'h0072, 5'd7, 5'd3, 3'd3, 0, lat);

    // Single line clear on the bottom row
    do_clear();
    for (int i = 0; i < 4; i++) begin
      do_lock(16'h000F, 5'(i * 4), 5'd19, 3'd0, 0, lat);
      chk("line_pre_lines", 32'(o_lines), 0);
    end
    do_lock(16'h000F, 5'd16, 5'd19, 3'd0, 0, lat);
    chk("line_lines", 32'(o_lines), 1);
    chk_f("line_field", o_field, '0);
    chk("line_lat", 32'(lat), 23);

    // Two lines at once, with a leftover cell above that must drop by two
    do_lock(16'h0001, 5'd2, 5'd10, 3'd0, 0, lat);
    for (int i = 0; i < 5; i++) do_lock(16'h00FF, 5'(i * 4), 5'd18, 3'd0, 0, lat);
    chk("line2_lines", 32'(o_lines), 2);
    chk("line2_lat", 32'(lat), 24);
    e = '0; e[12*20+2] = 1'b1;
    chk_f("line2_field", o_field, e);

    // Out of bounds, then overlap with identical lock
    do_clear();
    do_lock(16'h000F, 5'd18, 5'd0, 3'd0, 0, lat);
    e = '0; e[18] = 1'b1; e[19] = 1'b1;
    chk_f("oob_field", o_field, e);
    chk("oob_flag", 32'(o_oob), 1);
    chk("oob_ovl", 32'(o_ovl), 0);
    do_lock(16'h000F, 5'd18, 5'd0, 3'd0, 0, lat);
    chk_f("ovl_field", o_field, e);
    chk("ovl_flag", 32'(o_ovl), 1);

    // Far corner: every cell lands outside the field
    do_lock(16'hFFFF, 5'd31, 5'd31, 3'd2, 0, lat);
    chk_f("far_field", o_field, e);
    chk("far_oob", 32'(o_oob), 1);
    chk("far_ovl", 32'(o_ovl), 0);

    // start and clear together: clear wins and no lock runs
    done_cnt = 0;
    block = 16'h000F; pos_x = 5'd0; pos_y = 5'd0; rot = 3'd0;
    start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    chk_f("arb_field", o_field, '0);
    chk("arb_busy", 32'(o_busy), 0);
    repeat (4) tick();
    chk("arb_nodone", 32'(done_cnt), 0);

    // start pulsed while busy is dropped
    done_cnt = 0;
    do_lock(16'h0033, 5'd0, 5'd0, 3'd0, 5, lat);
    repeat (30) tick();
    chk("busy_start_lat", 32'(lat), 22);
    chk("busy_start_dones", 32'(done_cnt), 1);

    // Reset in the middle of a lock
    block = 16'h0033; pos_x = 5'd4; pos_y = 5'd4; rot = 3'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk_f("midrst_field", o_field, '0);
    chk("midrst_busy", 32'(o_busy), 0);
    chk("midrst_lines", 32'(o_lines), 0);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
